alu_seq_ctrl: RTL and testbench

Sequencing stage directly upstream of the `alu` block, which also consumes the ALU's results. It accepts 20-bit register-form instructions over a valid/ready handshake and reads operands from a 4×8 register file. It drives the ALU's `opcode`/`a`/`b` from registered operands, then captures `y`/`zero`/`overflow` and presents them downstream. On result handshake it writes `y` back to the destination register.

---
 rtl/alu_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: issues one register-form instruction at a time to an external
// ALU, captures its result, presents it over a valid/ready handshake and
// writes it back into a 4x8 register file when the result is accepted.
module alu_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [19:0] in_instr,
  output logic [3:0]  alu_opcode,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_y,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_data,
  output logic        res_zero,
  output logic        res_ovf,
  output logic        res_err,
  output logic        err_sticky
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] opcode;
    logic       use_imm;
    logic [1:0] rd;
    logic [1:0] ra;
    logic [1:0] rb;
    logic       rsvd;
    logic [7:0] imm;
  } instr_t;

  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_FIRST_ILLEGAL = 4'b1010;

  state_t     state_q, state_d;
  logic       live_q;       // low during reset so in_ready stays low there
  instr_t     instr;
  logic [7:0] regs [4];
  logic [1:0] rd_q;
  logic       accept;
  logic       wb_fire;
  logic       unused_rsvd;

  assign instr       = instr_t'(in_instr);
  // The reserved bit is decoded but deliberately has no effect.
  assign unused_rsvd = instr.rsvd;

  // State register plus a flag that marks the first cycle out of reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  // Next-state logic and handshake decodes of the registered state.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave a value unassigned and infer a latch.
    state_d   = state_q;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = live_q;
        if (live_q && in_valid) state_d = EXEC;
      end
      EXEC: state_d = WB;
      WB: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept  = in_ready & in_valid;
  assign wb_fire = res_valid & res_ready;

  // Operand capture at acceptance; ALU inputs hold until the next acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rd_q       <= '0;
    end else if (accept) begin
      alu_opcode <= instr.opcode;
      alu_a      <= regs[instr.ra];
      alu_b      <= instr.use_imm ? instr.imm : regs[instr.rb];
      rd_q       <= instr.rd;
    end
  end

  // Result capture in EXEC, overriding the ALU for illegal ops and divide by zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_data <= '0;
      res_zero <= 1'b0;
      res_ovf  <= 1'b0;
      res_err  <= 1'b0;
    end else if (state_q == EXEC) begin
      if (alu_opcode >= OP_FIRST_ILLEGAL) begin
        res_data <= 8'h00;
        res_zero <= 1'b1;
        res_ovf  <= 1'b0;
        res_err  <= 1'b1;
      end else if (alu_opcode == OP_DIV && alu_b == 8'h00) begin
        res_data <= 8'hFF;
        res_zero <= 1'b0;
        res_ovf  <= 1'b0;
        res_err  <= 1'b1;
      end else begin
        res_data <= alu_y;
        res_zero <= alu_zero;
        res_ovf  <= alu_overflow;
        res_err  <= 1'b0;
      end
    end
  end

  // Register file writeback and sticky error on the result handshake.
  always_ff @(posedge clk) begin
    // NOTE: this register file is architecturally cleared by reset, so it is
    // built from resettable flops rather than an inferred RAM.
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      err_sticky <= 1'b0;
    end else if (wb_fire) begin
      regs[rd_q] <= res_data;
      err_sticky <= err_sticky | res_err;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: an ALU model answers the DUT's
// operand outputs, and a register-file model predicts every result.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_instr;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_a, alu_b, alu_y;
  logic        alu_zero, alu_overflow;
  logic        res_valid, res_ready;
  logic [7:0]  res_data;
  logic        res_zero, res_ovf, res_err, err_sticky;
  logic [10:0] res_all;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_regs [4];
  logic       ref_sticky;

  always #5 clk = ~clk;

  alu_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_zero(res_zero), .res_ovf(res_ovf), .res_err(res_err),
    .err_sticky(err_sticky)
  );

  assign res_all = {res_data, res_zero, res_ovf, res_err};

  // Behavioural ALU: returns {y, zero, overflow}. Divide by zero and
  // illegal opcodes return junk that the DUT must discard.
  function automatic logic [9:0] alu_model(input logic [3:0] op,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
    logic [7:0] y;
    logic       v;
    y = 8'h33;
    v = 1'b0;
    case (op)
      4'd0: begin y = a + b; v = (a[7] == b[7]) && (y[7] != a[7]); end
      4'd1: begin y = a - b; v = (a[7] != b[7]) && (y[7] != a[7]); end
      4'd2: y = a & b;
      4'd3: if (b == 8'h00) begin y = 8'h5A; v = 1'b1; end else y = a / b;
      4'd4: y = a | b;
      4'd5: y = a ^ b;
      4'd6: begin y = a << 1; v = a[7]; end
      4'd7: y = a >> 1;
      4'd8: y = ~a;
      4'd9: y = a * b;
      default: begin y = 8'h33; v = 1'b1; end
    endcase
    return {y, (y == 8'h00), v};
  endfunction

  assign {alu_y, alu_zero, alu_overflow} = alu_model(alu_opcode, alu_a, alu_b);

  // Expected {data, zero, ovf, err} from the block's result rules.
  function automatic logic [10:0] expect_res(input logic [3:0] op,
                                             input logic [7:0] a,
                                             input logic [7:0] b);
    if (op >= 4'd10)                   return {8'h00, 1'b1, 1'b0, 1'b1};
    else if (op == 4'd3 && b == 8'h00) return {8'hFF, 1'b0, 1'b0, 1'b1};
    else                               return {alu_model(op, a, b), 1'b0};
  endfunction

  function automatic logic [19:0] mk(input logic [3:0] op, input logic ui,
                                     input logic [1:0] rd, input logic [1:0] ra,
                                     input logic [1:0] rb, input logic [7:0] imm);
    return {op, ui, rd, ra, rb, 1'b0, imm};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) ref_regs[i] = 8'h00;
    ref_sticky = 1'b0;
  endtask

  // Issues one instruction from IDLE, holds backpressure for 'hold' cycles
  // (pulsing a stray instruction meanwhile) and checks every stage.
  task automatic do_instr(input logic [19:0] ins, input int hold);
    logic [3:0]  op;
    logic [1:0]  rd;
    logic [7:0]  ea, eb;
    logic [10:0] eres;
    op   = ins[19:16];
    rd   = ins[14:13];
    ea   = ref_regs[ins[12:11]];
    eb   = ins[15] ? ins[7:0] : ref_regs[ins[10:9]];
    eres = expect_res(op, ea, eb);

    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready: got %b expected 1", in_ready);
    end
    in_valid  = 1'b1;
    in_instr  = ins;
    res_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_instr = 20'($urandom);
    checks++;
    if ({alu_opcode, alu_a, alu_b} !== {op, ea, eb}) begin
      errors++;
      $display("FAIL alu_inputs: got %h/%h/%h expected %h/%h/%h",
               alu_opcode, alu_a, alu_b, op, ea, eb);
    end
    checks++;
    if ({in_ready, res_valid} !== 2'b00) begin
      errors++;
      $display("FAIL exec_flags: got ready/valid %b expected 00", {in_ready, res_valid});
    end
    @(posedge clk); #1;
    checks++;
    if ({in_ready, res_valid} !== 2'b01) begin
      errors++;
      $display("FAIL wb_flags: got ready/valid %b expected 01", {in_ready, res_valid});
    end
    checks++;
    if (res_all !== eres) begin
      errors++;
      $display("FAIL result op=%h: got %h expected %h", op, res_all, eres);
    end
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_instr = 20'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({in_ready, res_valid, res_all, alu_opcode, alu_a, alu_b} !==
          {2'b01, eres, op, ea, eb}) begin
        errors++;
        $display("FAIL hold_stable cycle %0d: got rv=%b res=%h alu=%h/%h/%h expected rv=01 res=%h alu=%h/%h/%h",
                 h, {in_ready, res_valid}, res_all, alu_opcode, alu_a, alu_b, eres, op, ea, eb);
      end
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    ref_regs[rd] = eres[10:3];
    ref_sticky   = ref_sticky | eres[0];
    checks++;
    if ({in_ready, res_valid, err_sticky} !== {2'b10, ref_sticky}) begin
      errors++;
      $display("FAIL after_handshake: got ready/valid/sticky %b expected %b",
               {in_ready, res_valid, err_sticky}, {2'b10, ref_sticky});
    end
  endtask

  // Reads every register back through alu_a (R[i] + 0 written to itself).
  task automatic test_regs();
    for (int i = 0; i < 4; i++) do_instr(mk(4'd0, 1'b1, 2'(i), 2'(i), 2'd0, 8'h00), 0);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, res_valid, alu_opcode, alu_a, alu_b, res_all, err_sticky} !== 34'd0) begin
      errors++;
      $display("FAIL reset_state: got rv=%b alu=%h/%h/%h res=%h sticky=%b expected all zero",
               {in_ready, res_valid}, alu_opcode, alu_a, alu_b, res_all, err_sticky);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, res_valid} !== 2'b10) begin
      errors++;
      $display("FAIL ready_after_reset: got %b expected 10", {in_ready, res_valid});
    end
    model_reset();
    test_regs();
  endtask

  task automatic test_add_sub();
    do_instr(mk(4'd0, 1'b1, 2'd1, 2'd0, 2'd0, 8'h05), 0);
    checks++;
    if ({res_data, res_zero} !== {8'h05, 1'b0}) begin
      errors++;
      $display("FAIL load_r1: got %h/%b expected 05/0", res_data, res_zero);
    end
    do_instr(mk(4'd0, 1'b1, 2'd2, 2'd1, 2'd0, 8'h7D), 0);
    checks++;
    if ({res_data, res_ovf} !== {8'h82, 1'b1}) begin
      errors++;
      $display("FAIL add_ovf: got %h/%b expected 82/1", res_data, res_ovf);
    end
    do_instr(mk(4'd1, 1'b0, 2'd2, 2'd2, 2'd2, 8'h00), 0);
    checks++;
    if ({res_data, res_zero} !== {8'h00, 1'b1}) begin
      errors++;
      $display("FAIL sub_zero: got %h/%b expected 00/1", res_data, res_zero);
    end
  endtask

  task automatic test_div();
    do_instr(mk(4'd3, 1'b1, 2'd3, 2'd1, 2'd0, 8'h00), 0);
    checks++;
    if ({res_data, res_err, err_sticky} !== {8'hFF, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL div_zero: got %h/%b/%b expected ff/1/1", res_data, res_err, err_sticky);
    end
    do_instr(mk(4'd3, 1'b1, 2'd3, 2'd1, 2'd0, 8'h02), 0);
    checks++;
    if ({res_data, res_err, err_sticky} !== {8'h02, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL div_two: got %h/%b/%b expected 02/0/1", res_data, res_err, err_sticky);
    end
    test_regs();
  endtask

  task automatic test_illegal();
    do_instr(mk(4'hC, 1'b0, 2'd0, 2'd1, 2'd2, 8'h00), 0);
    checks++;
    if ({res_data, res_zero, res_err} !== {8'h00, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL illegal_op: got %h/%b/%b expected 00/1/1", res_data, res_zero, res_err);
    end
  endtask

  task automatic test_backpressure();
    do_instr(mk(4'd4, 1'b1, 2'd0, 2'd1, 2'd0, 8'h30), 5);
    test_regs();
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    in_instr = mk(4'd0, 1'b1, 2'd3, 2'd0, 2'd0, 8'hAA);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, res_valid, alu_opcode, alu_a, alu_b, res_all, err_sticky} !== 34'd0) begin
      errors++;
      $display("FAIL mid_reset_state: got rv=%b alu=%h/%h/%h res=%h sticky=%b expected all zero",
               {in_ready, res_valid}, alu_opcode, alu_a, alu_b, res_all, err_sticky);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    test_regs();
    do_instr(mk(4'd0, 1'b1, 2'd3, 2'd0, 2'd0, 8'hAA), 0);
    checks++;
    if (res_data !== 8'hAA) begin
      errors++;
      $display("FAIL after_mid_reset: got %h expected aa", res_data);
    end
    test_regs();
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++)
      do_instr(20'($urandom), int'($urandom_range(0, 2)));
    test_regs();
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_div();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
